// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;

  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int COUNT_W = count_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline (master) and the mul/div unit (slave).
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_E;
  logic [1:0]            muldivOp_E;
  logic [DATA_WIDTH-1:0] srcA_E;
  logic [DATA_WIDTH-1:0] srcB_E;
  logic                  flush_E;
  logic                  stall_E;
  logic                  done_E;
  logic [DATA_WIDTH-1:0] result_E;

  modport master (
    output start_E, muldivOp_E, srcA_E, srcB_E, flush_E,
    input  stall_E, done_E, result_E
  );

  modport slave (
    input  start_E, muldivOp_E, srcA_E, srcB_E, flush_E,
    output stall_E, done_E, result_E
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    is_div,
  input  logic [2*DATA_WIDTH-1:0] acc_in,
  input  logic [DATA_WIDTH-1:0]   src_in,
  input  logic [DATA_WIDTH-1:0]   operand,
  output logic [2*DATA_WIDTH-1:0] acc_out,
  output logic [DATA_WIDTH-1:0]   src_out
);
  localparam int W = DATA_WIDTH;

  logic [W:0]   sum;
  logic [W:0]   rem_shift;
  logic [W-1:0] diff;

  // acc holds {upper product, lower product} for multiply, {remainder, quotient} for divide
  always_comb begin
    sum       = {1'b0, acc_in[2*W-1:W]} + (src_in[0] ? {1'b0, operand} : '0);
    rem_shift = {acc_in[2*W-1:W], src_in[W-1]};
    diff      = rem_shift[W-1:0] - operand;
    if (is_div) begin
      src_out = {src_in[W-2:0], 1'b0};
      if (rem_shift >= {1'b0, operand}) begin
        acc_out = {diff, acc_in[W-2:0], 1'b1};
      end else begin
        acc_out = {rem_shift[W-1:0], acc_in[W-2:0], 1'b0};
      end
    end else begin
      src_out = {1'b0, src_in[W-1:1]};
      acc_out = {sum, acc_in[W-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU engine; stalls the pipeline while busy
// and presents the result for exactly one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = count_width(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_next;
  logic [W-1:0]     src;
  logic [W-1:0]     src_next;
  logic [W-1:0]     operand;
  logic [W-1:0]     result;
  muldiv_op_t       op;
  logic             div_zero;
  logic             start_ok;
  logic             new_div_zero;

  assign start_ok     = (state == S_IDLE) && bus.start_E && !bus.flush_E;
  assign new_div_zero = bus.muldivOp_E[1] && (bus.srcB_E == '0);

  muldiv_step #(.DATA_WIDTH(W)) u_step (
    .is_div  (op[1]),
    .acc_in  (acc),
    .src_in  (src),
    .operand (operand),
    .acc_out (acc_next),
    .src_out (src_next)
  );

  // src is the operand consumed bit by bit (multiplier or dividend); operand stays fixed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      src      <= '0;
      operand  <= '0;
      op       <= MUL;
      div_zero <= 1'b0;
    end else if (bus.flush_E) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_E) begin
            op       <= muldiv_op_t'(bus.muldivOp_E);
            count    <= '0;
            acc      <= '0;
            div_zero <= new_div_zero;
            if (bus.muldivOp_E[1]) begin
              src     <= bus.srcA_E;
              operand <= bus.srcB_E;
            end else begin
              src     <= bus.srcB_E;
              operand <= bus.srcA_E;
            end
            state <= new_div_zero ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          acc   <= acc_next;
          src   <= src_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(W - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // On divide-by-zero src still holds the untouched dividend
  always_comb begin
    result = '0;
    if (state == S_DONE) begin
      case (op)
        MUL:     result = acc[W-1:0];
        MULHU:   result = acc[2*W-1:W];
        DIVU:    result = div_zero ? '1 : acc[W-1:0];
        REMU:    result = div_zero ? src : acc[2*W-1:W];
        default: result = '0;
      endcase
    end
  end

  assign bus.result_E = result;
  assign bus.done_E   = (state == S_DONE);
  assign bus.stall_E  = !rst && (start_ok || (state == S_BUSY));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, flush and reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;

  muldiv_if #(.DATA_WIDTH(W)) bus ();

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    bus.start_E    = start;
    bus.muldivOp_E = op;
    bus.srcA_E     = a;
    bus.srcB_E     = b;
  endtask

  // Called just after a falling edge; that half-cycle is cycle 0 of the op.
  // start_E is held until the DONE cycle, as the stalled instruction would do.
  task automatic runOperation(input string tag, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expResult, input int expCycle,
                              input bit scramble);
    int   cyc;
    logic gotDone;
    logic stallOk;
    applyStimulus(1'b1, op, a, b);
    #1;
    checkOutput({tag, " stall cycle0"}, 32'(bus.stall_E), 32'd1);
    cyc     = 0;
    gotDone = 1'b0;
    stallOk = 1'b1;
    while (!gotDone && cyc < 40) begin
      @(negedge clk);
      cyc++;
      #1;
      if (bus.done_E) begin
        gotDone = 1'b1;
      end else begin
        if (!bus.stall_E) stallOk = 1'b0;
        if (scramble && cyc == 5) applyStimulus(1'b1, ~op, 32'hDEADBEEF, 32'h00000003);
      end
    end
    checkOutput({tag, " done cycle"}, 32'(cyc), 32'(expCycle));
    checkOutput({tag, " result"}, bus.result_E, expResult);
    checkOutput({tag, " stall in done"}, 32'(bus.stall_E), 32'd0);
    checkOutput({tag, " stall while busy"}, 32'(stallOk), 32'd1);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, " done one cycle"}, 32'(bus.done_E), 32'd0);
    checkOutput({tag, " result cleared"}, bus.result_E, 32'd0);
    checkOutput({tag, " stall idle"}, 32'(bus.stall_E), 32'd0);
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    logic sawDone;
    sawDone = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (bus.done_E) sawDone = 1'b1;
    end
    checkOutput({tag, " no done"}, 32'(sawDone), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.flush_E = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset stall", 32'(bus.stall_E), 32'd0);
    checkOutput("reset done", 32'(bus.done_E), 32'd0);
    checkOutput("reset result", bus.result_E, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    runOperation("MUL 7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 33, 1'b0);
    runOperation("MULHU max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
    runOperation("MUL max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 1'b0);
    runOperation("DIVU 100/7", 2'b10, 32'd100, 32'd7, 32'h0000000E, 33, 1'b0);
    runOperation("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'h00000002, 33, 1'b0);
    runOperation("DIVU msb/1", 2'b10, 32'h80000000, 32'd1, 32'h80000000, 33, 1'b0);
    runOperation("DIVU 5/0", 2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    runOperation("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'h00000005, 1, 1'b0);

    // Flush a divide part-way through, then a fresh multiply must run normally
    applyStimulus(1'b1, 2'b10, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("flush stall busy", 32'(bus.stall_E), 32'd1);
    bus.flush_E = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    bus.flush_E = 1'b0;
    checkOutput("flush stall after", 32'(bus.stall_E), 32'd0);
    checkOutput("flush done after", 32'(bus.done_E), 32'd0);
    watchNoDone("flush", 40);
    runOperation("MUL 3x3", 2'b00, 32'd3, 32'd3, 32'h00000009, 33, 1'b0);

    // Asynchronous reset in the middle of a multiply
    applyStimulus(1'b1, 2'b00, 32'd7, 32'd6);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("rst stall before", 32'(bus.stall_E), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst stall", 32'(bus.stall_E), 32'd0);
    checkOutput("rst done", 32'(bus.done_E), 32'd0);
    checkOutput("rst result", bus.result_E, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
    #1;
    checkOutput("rst release stall", 32'(bus.stall_E), 32'd0);
    watchNoDone("rst", 40);

    // Inputs changing during BUSY must not disturb the latched operation
    runOperation("DIVU held", 2'b10, 32'h12345678, 32'h00000100, 32'h00123456, 33, 1'b1);
    runOperation("REMU held", 2'b11, 32'h12345678, 32'h00000100, 32'h00000078, 33, 1'b1);
    runOperation("MULHU held", 2'b01, 32'h12345678, 32'h00000100, 32'h00000012, 33, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide engine beside the ALU in the execute stage. It accepts one M-extension operation per request and computes it over 32 cycles. While the operation runs it holds the pipeline with a stall signal, then presents the result for one cycle. Squashed instructions are cancelled through a flush input.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start_E  input  1  execute-stage instruction is a mul/div op; sampled only in IDLE.
- muldivOp_E  input  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU.
- srcA_E  input  DATA_WIDTH  multiplicand / dividend.
- srcB_E  input  DATA_WIDTH  multiplier / divisor.
- flush_E  input  1  cancel any in-flight op.
- stall_E  output  1  hold fetch/decode/execute pipeline registers.
- done_E  output  1  result valid this cycle (single-cycle pulse).
- result_E  output  DATA_WIDTH  result; zero when done_E is low.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start_E=1 and flush_E=0, latch the operands and op, and clear the accumulator and count.
  - If the op is DIVU/REMU and srcB_E=0, go to DONE (divide-by-zero fast path); otherwise go to BUSY.
- BUSY, one iteration per cycle:
  - MUL/MULHU: 2×DATA_WIDTH shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator (DATA_WIDTH+1-bit sum, carry kept). Then shift the {carry, acc} register right by 1.
  - DIVU/REMU: restoring division. Shift remainder:quotient left 1 and bring in the next dividend MSB. If remainder ≥ divisor, subtract and set quotient LSB to 1.
  - The counter increments each cycle. On the iteration where count = DATA_WIDTH-1, go to DONE.
- DONE:
  - done_E=1. result_E is selected by op: MUL acc[DATA_WIDTH-1:0], MULHU acc[2·DATA_WIDTH-1:DATA_WIDTH], DIVU quotient, REMU remainder.
  - Divide by zero: DIVU gives all ones; REMU gives the dividend.
  - Always return to IDLE next cycle; a start_E in DONE is not accepted.
- stall_E = (IDLE & start_E & ~flush_E) | BUSY. It is low in DONE, so the pipeline advances and captures result_E.
- flush_E=1 in any state forces IDLE on the next edge. No done_E is produced and the latched state is discarded. Flush has priority over start.
- start_E during BUSY/DONE is ignored. The held instruction keeps start_E high until DONE, so no re-trigger occurs.

## Timing
- Reset (asynchronous): state IDLE, count 0, accumulator/operands 0. stall_E=0 (it follows start_E combinationally once out of reset), done_E=0, result_E=0.
- Normal op:
  - Start sampled at edge E0, then BUSY during cycles 1..DATA_WIDTH.
  - DONE in cycle DATA_WIDTH+1: done_E is high 33 cycles after the start cycle.
  - stall_E is high in cycles 0..32.
- Divide-by-zero: done_E in cycle 1; stall_E high only in cycle 0.
- Back-to-back: the earliest next start is sampled in the IDLE cycle following DONE.
- Reset asserted mid-operation: outputs clear immediately with no done_E. Operation restarts only on a new start_E after reset releases.

## Structure
- Shared package muldiv_pkg:
  - muldiv_op_t enum (MUL, MULHU, DIVU, REMU, matching the 2-bit encoding).
  - muldiv_state_t enum (IDLE, BUSY, DONE).
  - Count width constant $clog2(DATA_WIDTH)+1.
- One natural sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract), instantiated once. The FSM, counter and registers stay in muldiv_unit.
- The decoder drives muldivOp_E. The hazard unit ORs stall_E into its stall outputs. The result mux in execute selects result_E when done_E is high.

## Test plan
- MUL 7×6 → done_E in cycle 33, result_E=0x0000002A; stall_E high cycles 0–32 exactly.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result_E=0xFFFFFFFE; MUL of the same operands → 0x00000001.
- DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002; DIVU 0x80000000/1 → 0x80000000.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 0x00000005, each with done_E in cycle 1.
- flush_E pulsed in cycle 10 of a DIVU → IDLE next cycle, no done_E, stall_E low. A following MUL 3×3 → 9 in its own cycle 33.
- rst asserted mid-MUL (cycle 20) → stall_E/done_E/result_E drop to 0 asynchronously. Holding start_E during BUSY across a second op value does not change the result.
